// File: rtl/gshare_pht_scheduler_pkg.sv
// rtl/gshare_pht_scheduler_pkg.sv - shared types and constants for the gshare PHT scheduler
package FetchUnitTypes;

    // Default geometry of the predictor; the top module exposes these as overridable parameters.
    localparam int PHT_INDEX_BITS       = 10;
    localparam int GHR_BITS             = 10;
    localparam int PC_BITS              = 32;
    localparam int UPDATE_QUEUE_ENTRIES = 4;

    localparam int PHT_ENTRY_NUM = 1 << PHT_INDEX_BITS;

    typedef logic [PHT_INDEX_BITS-1:0] PHTIndex;
    typedef logic [1:0]                PHTCounter;
    typedef logic [GHR_BITS-1:0]       GlobalBranchHistory;

    // Weakly not taken: one taken outcome flips the prediction.
    localparam PHTCounter PHT_COUNTER_INIT = 2'b01;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        UPD_READ  = 2'd1,
        UPD_WRITE = 2'd2
    } PHTSchedState;

    typedef struct packed {
        PHTIndex index;
        logic    taken;
    } PHTUpdateEntry;

    // Two-bit saturating counter step towards the resolved direction.
    function automatic PHTCounter pht_counter_next(input PHTCounter cnt, input logic taken);
        PHTCounter nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != 2'b11) begin
                nxt = cnt + 2'b01;
            end
        end else begin
            if (cnt != 2'b00) begin
                nxt = cnt - 2'b01;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/gshare_pht_scheduler_branch_update_queue.sv
// rtl/gshare_pht_scheduler_branch_update_queue.sv - synchronous FIFO of pending PHT counter updates
module branch_update_queue #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full queue or a pop from an empty one is ignored rather than corrupting order.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Pointers and count; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
        end
    end

    // Entry storage; contents need no reset since the count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/gshare_pht_scheduler.sv
// rtl/gshare_pht_scheduler.sv - gshare PHT with lookup/update port scheduling and global history
module gshare_pht_scheduler
    import FetchUnitTypes::*;
#(
    parameter int PHT_INDEX_WIDTH    = PHT_INDEX_BITS,
    parameter int GHR_WIDTH          = GHR_BITS,
    parameter int PC_WIDTH           = PC_BITS,
    parameter int UPDATE_QUEUE_DEPTH = UPDATE_QUEUE_ENTRIES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lookupValid,
    input  logic [PC_WIDTH-1:0]        lookupPC,
    output logic                       lookupReady,
    output logic                       predValid,
    output logic                       isBranchTakenPredicted,
    output logic [PHT_INDEX_WIDTH-1:0] phtIndex,
    input  logic                       historyPushValid,
    input  logic                       historyPushTaken,
    input  logic                       resolveValid,
    input  logic [PHT_INDEX_WIDTH-1:0] resolvePhtIndex,
    input  logic                       resolveTaken,
    input  logic                       resolveMispredicted,
    output logic                       resolveReady
);

    localparam int PHT_DEPTH = 1 << PHT_INDEX_WIDTH;
    localparam int ENTRY_W   = PHT_INDEX_WIDTH + 1;
    localparam int CNT_W     = $clog2(UPDATE_QUEUE_DEPTH) + 1;

    PHTSchedState state_q;
    PHTSchedState state_d;

    PHTCounter pht_q [PHT_DEPTH];
    PHTCounter rmw_counter_q;

    logic [GHR_WIDTH-1:0]       spec_ghr_q;
    logic [GHR_WIDTH-1:0]       spec_ghr_d;
    logic [GHR_WIDTH-1:0]       commit_ghr_q;
    logic [GHR_WIDTH-1:0]       commit_ghr_d;

    logic                       pred_valid_q;
    logic                       pred_taken_q;
    logic [PHT_INDEX_WIDTH-1:0] pred_index_q;

    logic [PHT_INDEX_WIDTH-1:0] ghr_ext;
    logic [PHT_INDEX_WIDTH-1:0] lookup_idx;
    logic                       lookup_accept;
    logic                       rmw_read;
    logic                       rmw_write;
    logic                       resolve_accept;

    logic [ENTRY_W-1:0]         q_head;
    logic [PHT_INDEX_WIDTH-1:0] q_head_index;
    logic                       q_head_taken;
    logic                       q_full;
    logic                       q_empty;
    logic [CNT_W-1:0]           queue_count_unused;
    logic                       pc_bits_unused;

    // Only the word-index slice of the PC feeds the hash.
    assign pc_bits_unused = ^{lookupPC[PC_WIDTH-1:PHT_INDEX_WIDTH+2], lookupPC[1:0]};

    assign resolve_accept = resolveValid && !q_full;
    assign resolveReady   = !q_full;
    assign lookupReady    = lookup_accept;

    assign q_head_index = q_head[ENTRY_W-1:1];
    assign q_head_taken = q_head[0];

    assign predValid              = pred_valid_q;
    assign isBranchTakenPredicted = pred_taken_q;
    assign phtIndex               = pred_index_q;

    branch_update_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (UPDATE_QUEUE_DEPTH)
    ) u_update_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (resolve_accept),
        .push_data_i ({resolvePhtIndex, resolveTaken}),
        .pop_i       (rmw_write),
        .head_o      (q_head),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .count_o     (queue_count_unused)
    );

    // gshare hash: PC word index XOR the zero-extended speculative history.
    always_comb begin
        ghr_ext                  = '0;
        ghr_ext[GHR_WIDTH-1:0]   = spec_ghr_q;
        lookup_idx               = lookupPC[PHT_INDEX_WIDTH+1:2] ^ ghr_ext;
    end

    // Port arbitration: a full queue preempts lookups, otherwise lookups win and idle cycles drain updates.
    always_comb begin
        state_d       = state_q;
        lookup_accept = 1'b0;
        rmw_read      = 1'b0;
        rmw_write     = 1'b0;
        case (state_q)
            IDLE: begin
                if (q_full) begin
                    state_d = UPD_READ;
                end else if (lookupValid) begin
                    lookup_accept = 1'b1;
                end else if (!q_empty) begin
                    state_d = UPD_READ;
                end
            end
            UPD_READ: begin
                rmw_read = 1'b1;
                state_d  = UPD_WRITE;
            end
            UPD_WRITE: begin
                rmw_write = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scheduler state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // PHT storage; reset wins over a same-cycle RMW write so an interrupted update leaves no trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht_q[i] <= PHT_COUNTER_INIT;
            end
        end else if (rmw_write) begin
            pht_q[q_head_index] <= pht_counter_next(rmw_counter_q, q_head_taken);
        end
    end

    // PHT read side: registered prediction for fetch and the latched counter for the RMW.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_index_q  <= '0;
            rmw_counter_q <= PHT_COUNTER_INIT;
        end else begin
            pred_valid_q <= lookup_accept;
            if (lookup_accept) begin
                pred_index_q <= lookup_idx;
                pred_taken_q <= pht_q[lookup_idx][1];
            end
            if (rmw_read) begin
                rmw_counter_q <= pht_q[q_head_index];
            end
        end
    end

    // History next-state: resolves build the committed history; a mispredict snaps speculation back to it.
    always_comb begin
        commit_ghr_d = commit_ghr_q;
        spec_ghr_d   = spec_ghr_q;
        if (resolve_accept) begin
            commit_ghr_d = {commit_ghr_q[GHR_WIDTH-2:0], resolveTaken};
        end
        if (resolve_accept && resolveMispredicted) begin
            spec_ghr_d = commit_ghr_d;
        end else if (historyPushValid) begin
            spec_ghr_d = {spec_ghr_q[GHR_WIDTH-2:0], historyPushTaken};
        end
    end

    // History registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            spec_ghr_q   <= '0;
            commit_ghr_q <= '0;
        end else begin
            spec_ghr_q   <= spec_ghr_d;
            commit_ghr_q <= commit_ghr_d;
        end
    end

endmodule
